psram_qpi_target: RTL and testbench
===================================

Name: psram_qpi_target

Overview:
- Synthesizable SPI/QPI PSRAM responder. It is the target-side counterpart of psram_controller.
- Decodes the enter-quad, exit-quad, quad-write and fast-quad-read command bytes, then services them from an on-chip byte RAM.
- Used as the far end of the psram_controller chip interface in loopback builds and benches. The same bitstream then exercises the controller with no physical PSRAM fitted.
- Oversamples the incoming sclk on the system clock.

Parameters:
- MEM_ADDR_WIDTH, 12, log2 of backing RAM depth in bytes. Bus address is taken modulo depth.
- PSRAM_ADDRESS_WIDTH, 24, address bits carried on the bus (6 QPI nibbles).
- READ_WAIT_CYCLES, 6, dummy sclk cycles between last address nibble and first read nibble.
- CMD_ENTER_QUAD, 8'h35, SPI-mode command that enters QPI.
- CMD_EXIT_QUAD, 8'hF5, QPI-mode command that exits QPI.
- CMD_QUAD_WRITE, 8'h38, QPI write command.
- CMD_FAST_QUAD_READ, 8'hEB, QPI read command.

Ports:
- clk  in  1  system clock; must be at least 4x the sclk frequency.
- reset  in  1  synchronous, active-high reset.
- chip_enable  in  1  active-low chip select from the controller.
- sclk  in  1  serial clock from the controller (asynchronous to clk).
- sio_in  in  4  sampled sio[3:0] pins. In SPI mode only sio_in[0] (SI) is used.
- sio_out  out  4  data driven toward the controller.
- sio_oe  out  4  per-pin output enable; the top level builds the tristates.
- qpi_mode  out  1  1 = QPI mode active.
- busy  out  1  high while chip_enable is low and state is not IDLE.
- cmd_err  out  1  one-clk pulse when an unsupported command byte is decoded.
- write_strobe  out  1  one-clk pulse for each byte committed to RAM.

Behaviour:
- Reset values: sio_out=0, sio_oe=0, qpi_mode=0, busy=0, cmd_err=0, write_strobe=0, state=IDLE, all counters 0. RAM contents are not cleared.
- Reset mid-transaction aborts to IDLE immediately; any partial byte is lost.
- Input synchronisation:
  - chip_enable, sclk and sio_in each pass through a 2-flop synchroniser.
  - A 3rd sclk flop gives sclk_rise and sclk_fall single-clk strobes.
  - All bus events below occur on those strobes, 3 clk after the pin edge.
- chip_enable deassert (synced high) forces IDLE from any state in the same clk. It also clears sio_oe and drops any partial byte or address.
- State machine:
  - IDLE: on synced chip_enable low, go to CMD.
  - CMD:
    - SPI mode: shift 8 bits MSB-first from sio_in[0] on sclk_rise.
    - QPI mode: shift 2 nibbles, high nibble first.
    - On the final bit/nibble, decode:
      - 35 in SPI mode: set qpi_mode=1, go to IGNORE.
      - F5 in QPI mode: set qpi_mode=0, go to IGNORE.
      - 38 or EB in QPI mode: go to ADDR.
      - Anything else, including 35 in QPI mode and any SPI byte other than 35: pulse cmd_err, go to IGNORE.
  - ADDR: 6 nibbles MSB-first on sclk_rise into a 24-bit register. On the last nibble, go to WDATA (38) or WAIT (EB), and issue the RAM read for EB.
  - WAIT: count READ_WAIT_CYCLES sclk_rise strobes, then go to RDATA.
  - RDATA:
    - On entry, set sio_oe=4'hF.
    - On each sclk_fall, drive the next nibble, high nibble first; the first nibble is driven on the first sclk_fall after entry.
    - After the low nibble is driven, increment the address modulo 2^MEM_ADDR_WIDTH and prefetch the next byte.
    - RAM has 1-clk read latency, which always completes before the next sclk_fall.
  - WDATA:
    - Collect nibble pairs on sclk_rise, high nibble first.
    - On the second nibble, write the byte to RAM at the current address, pulse write_strobe, and increment the address with wrap.
  - IGNORE: discard all sclk activity until chip_enable rises.
- sio_oe is nonzero only in RDATA.
- Address bits above MEM_ADDR_WIDTH are ignored.
- Bursts are unbounded; the address wraps 0xFFF to 0x000 at the default depth.

Decomposition:
- Shared package psram_pkg holds:
  - the command constants (shared with psram_controller);
  - a state enum typedef {IDLE, CMD, ADDR, WAIT, RDATA, WDATA, IGNORE}.
- One sub-module, psram_target_mem: single-port byte RAM, synchronous write, 1-clk registered read, depth 2^MEM_ADDR_WIDTH.

Test Plan:
- Reset, then idle for 10 clk -> qpi_mode=0, sio_oe=0, busy=0.
- SPI: chip_enable low, shift 8'h35 on sio_in[0], chip_enable high -> qpi_mode=1, cmd_err=0.
- QPI write: 38, address 000010, data A5 3C -> mem[0x010]=A5, mem[0x011]=3C, two write_strobe pulses.
- QPI read: EB, address 000010, 6 dummy clocks, 4 data clocks -> sio_out nibbles A,5,3,C; sio_oe=F only across the data clocks.
- Write 38, address 000FFF, data 11 22 -> mem[0xFFF]=11, mem[0x000]=22 (wrap).
- Abort and error paths:
  - chip_enable high after one write data nibble -> no write_strobe; RAM unchanged.
  - Then QPI command 12 -> cmd_err pulses once, state returns to IDLE on chip_enable high.
  - Then F5 -> qpi_mode=0.

Source files
------------

// File: rtl/psram_pkg.sv
// psram_pkg: constants and types shared by the PSRAM controller and the
// loopback target.
//   - PSRAM_CMD_* : command bytes understood on the chip interface
//   - state_t     : target-side protocol state
package psram_pkg;

    localparam logic [7:0] PSRAM_CMD_ENTER_QUAD     = 8'h35;
    localparam logic [7:0] PSRAM_CMD_EXIT_QUAD      = 8'hF5;
    localparam logic [7:0] PSRAM_CMD_QUAD_WRITE     = 8'h38;
    localparam logic [7:0] PSRAM_CMD_FAST_QUAD_READ = 8'hEB;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WAIT,
        RDATA,
        WDATA,
        IGNORE
    } state_t;

endpackage

// File: rtl/psram_qpi_target_if.sv
// psram_qpi_target_if: PSRAM chip-interface pins as seen between the
// controller (master) and the target (slave).
//   chip_enable : active-low chip select, master -> slave
//   sclk        : serial clock, master -> slave
//   sio_in      : sampled sio[3:0], master -> slave
//   sio_out     : data toward the master, slave -> master
//   sio_oe      : per-pin output enable for sio_out, slave -> master
interface psram_qpi_target_if;
    logic       chip_enable;
    logic       sclk;
    logic [3:0] sio_in;
    logic [3:0] sio_out;
    logic [3:0] sio_oe;

    modport master (
        output chip_enable, sclk, sio_in,
        input  sio_out, sio_oe
    );

    modport slave (
        input  chip_enable, sclk, sio_in,
        output sio_out, sio_oe
    );
endinterface

// File: rtl/psram_target_mem.sv
// psram_target_mem: single-port byte RAM behind the PSRAM target.
//   clk   : system clock
//   we    : write enable, writes wdata at addr
//   addr  : byte address (shared by read and write)
//   wdata : write data
//   rdata : registered read data, mem[addr] one clk after addr is presented
// Contents are not reset.
module psram_target_mem #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            wdata,
    output logic [7:0]            rdata
);

    logic [7:0] mem [0:(1 << ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/psram_qpi_target.sv
// psram_qpi_target: SPI/QPI PSRAM responder backed by an on-chip byte RAM,
// used as the far end of psram_controller in loopback builds.
//   clk          : system clock, at least 4x sclk
//   reset        : synchronous, active-high
//   bus          : chip pins (chip_enable, sclk, sio_in in; sio_out, sio_oe out)
//   qpi_mode     : 1 while QPI mode is active
//   busy         : chip selected and a transaction in progress
//   cmd_err      : one-clk pulse on an unsupported command byte
//   write_strobe : one-clk pulse per byte committed to RAM
//
// state  | meaning
// IDLE   | deselected, waiting for chip_enable low
// CMD    | shifting in the command byte (8 bits SPI / 2 nibbles QPI)
// ADDR   | shifting in the address nibbles
// WAIT   | counting dummy sclk cycles before read data
// RDATA  | driving read nibbles on sclk falling edges
// WDATA  | collecting write nibble pairs and committing bytes
// IGNORE | discarding sclk activity until chip_enable rises
module psram_qpi_target
    import psram_pkg::*;
#(
    parameter int         MEM_ADDR_WIDTH      = 12,
    parameter int         PSRAM_ADDRESS_WIDTH = 24,
    parameter int         READ_WAIT_CYCLES    = 6,
    parameter logic [7:0] CMD_ENTER_QUAD      = PSRAM_CMD_ENTER_QUAD,
    parameter logic [7:0] CMD_EXIT_QUAD       = PSRAM_CMD_EXIT_QUAD,
    parameter logic [7:0] CMD_QUAD_WRITE      = PSRAM_CMD_QUAD_WRITE,
    parameter logic [7:0] CMD_FAST_QUAD_READ  = PSRAM_CMD_FAST_QUAD_READ
) (
    input  logic                clk,
    input  logic                reset,
    psram_qpi_target_if.slave   bus,
    output logic                qpi_mode,
    output logic                busy,
    output logic                cmd_err,
    output logic                write_strobe
);

    localparam int ADDR_NIBBLES = PSRAM_ADDRESS_WIDTH / 4;

    logic       ce_s1, ce_s2;
    logic       sclk_s1, sclk_s2, sclk_s3;
    logic [3:0] sio_s1, sio_s2;
    logic       sclk_rise, sclk_fall;

    // chip_enable syncs to the deselected level so busy stays low in reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ce_s1   <= 1'b1;
            ce_s2   <= 1'b1;
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            sio_s1  <= 4'h0;
            sio_s2  <= 4'h0;
        end else begin
            ce_s1   <= bus.chip_enable;
            ce_s2   <= ce_s1;
            sclk_s1 <= bus.sclk;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            sio_s1  <= bus.sio_in;
            sio_s2  <= sio_s1;
        end
    end

    assign sclk_rise = sclk_s2 & ~sclk_s3;
    assign sclk_fall = ~sclk_s2 & sclk_s3;

    state_t                    state;
    logic [7:0]                cnt;
    logic [6:0]                shift;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [MEM_ADDR_WIDTH-1:0] wr_addr;
    logic [7:0]                wr_data;
    logic                      nib_lo;
    logic                      is_read;
    logic [3:0]                sio_out_q;
    logic [3:0]                sio_oe_q;
    logic [7:0]                cmd_byte;
    logic [7:0]                mem_rdata;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;

    // Command byte as it will look once the current bit/nibble is shifted in.
    assign cmd_byte = qpi_mode ? {shift[3:0], sio_s2} : {shift, sio_s2[0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            shift        <= 7'd0;
            addr         <= '0;
            wr_addr      <= '0;
            wr_data      <= 8'h00;
            nib_lo       <= 1'b0;
            is_read      <= 1'b0;
            sio_out_q    <= 4'h0;
            sio_oe_q     <= 4'h0;
            qpi_mode     <= 1'b0;
            cmd_err      <= 1'b0;
            write_strobe <= 1'b0;
        end else begin
            cmd_err      <= 1'b0;
            write_strobe <= 1'b0;
            if (ce_s2) begin
                state     <= IDLE;
                cnt       <= 8'd0;
                shift     <= 7'd0;
                nib_lo    <= 1'b0;
                sio_out_q <= 4'h0;
                sio_oe_q  <= 4'h0;
            end else begin
                unique case (state)
                    IDLE: begin
                        state <= CMD;
                        cnt   <= qpi_mode ? 8'd1 : 8'd7;
                        shift <= 7'd0;
                    end
                    CMD: if (sclk_rise) begin
                        shift <= qpi_mode ? {shift[2:0], sio_s2} : {shift[5:0], sio_s2[0]};
                        if (cnt != 8'd0) begin
                            cnt <= cnt - 8'd1;
                        end else begin
                            state <= IGNORE;
                            if (!qpi_mode && cmd_byte == CMD_ENTER_QUAD) begin
                                qpi_mode <= 1'b1;
                            end else if (qpi_mode && cmd_byte == CMD_EXIT_QUAD) begin
                                qpi_mode <= 1'b0;
                            end else if (qpi_mode && (cmd_byte == CMD_QUAD_WRITE ||
                                                      cmd_byte == CMD_FAST_QUAD_READ)) begin
                                state   <= ADDR;
                                is_read <= (cmd_byte == CMD_FAST_QUAD_READ);
                                cnt     <= 8'(ADDR_NIBBLES - 1);
                            end else begin
                                cmd_err <= 1'b1;
                            end
                        end
                    end
                    ADDR: if (sclk_rise) begin
                        // Bits above the RAM depth fall off the top of the register.
                        addr <= MEM_ADDR_WIDTH'({addr, sio_s2});
                        if (cnt != 8'd0) begin
                            cnt <= cnt - 8'd1;
                        end else begin
                            nib_lo <= 1'b0;
                            if (is_read) begin
                                // The RAM reads addr every clk, so the first byte
                                // is ready one clk after the address completes.
                                state <= WAIT;
                                cnt   <= 8'(READ_WAIT_CYCLES - 1);
                            end else begin
                                state <= WDATA;
                            end
                        end
                    end
                    WAIT: if (sclk_rise) begin
                        if (cnt != 8'd0) begin
                            cnt <= cnt - 8'd1;
                        end else begin
                            state    <= RDATA;
                            sio_oe_q <= 4'hF;
                            nib_lo   <= 1'b0;
                        end
                    end
                    RDATA: if (sclk_fall) begin
                        if (!nib_lo) begin
                            sio_out_q <= mem_rdata[7:4];
                            nib_lo    <= 1'b1;
                        end else begin
                            sio_out_q <= mem_rdata[3:0];
                            nib_lo    <= 1'b0;
                            addr      <= addr + MEM_ADDR_WIDTH'(1);
                        end
                    end
                    WDATA: if (sclk_rise) begin
                        if (!nib_lo) begin
                            shift  <= 7'(sio_s2);
                            nib_lo <= 1'b1;
                        end else begin
                            wr_data      <= {shift[3:0], sio_s2};
                            wr_addr      <= addr;
                            write_strobe <= 1'b1;
                            addr         <= addr + MEM_ADDR_WIDTH'(1);
                            nib_lo       <= 1'b0;
                        end
                    end
                    IGNORE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // The write is committed the clk after the address has already advanced,
    // so the RAM port takes the latched write address during that clk.
    assign mem_addr = write_strobe ? wr_addr : addr;

    psram_target_mem #(
        .ADDR_WIDTH (MEM_ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (write_strobe),
        .addr  (mem_addr),
        .wdata (wr_data),
        .rdata (mem_rdata)
    );

    assign bus.sio_out = sio_out_q;
    assign bus.sio_oe  = sio_oe_q;
    assign busy        = ~ce_s2 & (state != IDLE);

endmodule

// File: tb/tb_psram_qpi_target.sv
module tb_psram_qpi_target;

    localparam time TCLK  = 10;
    localparam time THALF = 40;

    typedef struct {
        bit          is_write;
        logic [23:0] addr;
        logic [7:0]  d0;
        logic [7:0]  d1;
        int          exp_strobes;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic qpi_mode, busy, cmd_err, write_strobe;

    psram_qpi_target_if bus();

    psram_qpi_target dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .qpi_mode     (qpi_mode),
        .busy         (busy),
        .cmd_err      (cmd_err),
        .write_strobe (write_strobe)
    );

    always #(TCLK/2) clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int ws_cnt = 0;
    int err_cnt = 0;

    always @(negedge clk) begin
        if (write_strobe === 1'b1) ws_cnt <= ws_cnt + 1;
        if (cmd_err === 1'b1) err_cnt <= err_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sclk_pulse();
        #THALF bus.sclk = 1'b1;
        #THALF bus.sclk = 1'b0;
    endtask

    task automatic put_nib(input logic [3:0] n);
        bus.sio_in = n;
        sclk_pulse();
    endtask

    task automatic put_qpi(input logic [7:0] b);
        put_nib(b[7:4]);
        put_nib(b[3:0]);
    endtask

    task automatic put_spi(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            bus.sio_in = {3'b000, b[i]};
            sclk_pulse();
        end
    endtask

    task automatic put_addr(input logic [23:0] a);
        for (int k = 5; k >= 0; k--) put_nib(a[k*4 +: 4]);
    endtask

    // Samples the pins just before the rising sclk edge of this cycle.
    task automatic get_nib(output logic [3:0] n, output logic [3:0] oe);
        #(THALF - 2);
        n  = bus.sio_out;
        oe = bus.sio_oe;
        #2 bus.sclk = 1'b1;
        #THALF bus.sclk = 1'b0;
    endtask

    task automatic cs_low();
        bus.chip_enable = 1'b0;
        #THALF;
    endtask

    task automatic cs_high();
        #THALF;
        bus.chip_enable = 1'b1;
        #(8*TCLK);
    endtask

    task automatic do_write(input string tag, input logic [23:0] a, input logic [7:0] d0,
                            input logic [7:0] d1, input int exp_strobes);
        int ws0;
        ws0 = ws_cnt;
        cs_low();
        put_qpi(8'h38);
        put_addr(a);
        put_qpi(d0);
        put_qpi(d1);
        #(8*TCLK);
        check({tag, "_strobes"}, ws_cnt - ws0, exp_strobes);
        cs_high();
    endtask

    task automatic do_read(input string tag, input logic [23:0] a, input logic [15:0] exp16);
        logic [3:0] n, oe;
        cs_low();
        put_qpi(8'hEB);
        put_addr(a);
        for (int k = 0; k < 6; k++) begin
            get_nib(n, oe);
            check($sformatf("%s_dummy_oe%0d", tag, k), oe, 4'h0);
        end
        for (int k = 0; k < 4; k++) begin
            get_nib(n, oe);
            check($sformatf("%s_nib%0d", tag, k), n, exp16[15 - 4*k -: 4]);
            check($sformatf("%s_oe%0d", tag, k), oe, 4'hF);
        end
        cs_high();
    endtask

    vec_t vecs[7];

    initial begin
        int er0, ws0;
        logic [3:0] n, oe;

        vecs[0] = '{1'b1, 24'h000010, 8'hA5, 8'h3C, 2};
        vecs[1] = '{1'b0, 24'h000010, 8'hA5, 8'h3C, 0};
        vecs[2] = '{1'b1, 24'h000FFF, 8'h11, 8'h22, 2};
        vecs[3] = '{1'b0, 24'h000FFF, 8'h11, 8'h22, 0};
        vecs[4] = '{1'b1, 24'hABC020, 8'h5A, 8'hC3, 2};
        vecs[5] = '{1'b0, 24'h000020, 8'h5A, 8'hC3, 0};
        vecs[6] = '{1'b0, 24'h001010, 8'hA5, 8'h3C, 0};

        reset = 1'b1;
        bus.chip_enable = 1'b1;
        bus.sclk = 1'b0;
        bus.sio_in = 4'h0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #(10*TCLK);
        check("rst_qpi_mode", qpi_mode, 1'b0);
        check("rst_sio_oe", bus.sio_oe, 4'h0);
        check("rst_sio_out", bus.sio_out, 4'h0);
        check("rst_busy", busy, 1'b0);

        // SPI enter-quad
        er0 = err_cnt;
        cs_low();
        put_spi(8'h35);
        check("spi35_busy", busy, 1'b1);
        cs_high();
        check("spi35_qpi_mode", qpi_mode, 1'b1);
        check("spi35_cmd_err", err_cnt - er0, 0);
        check("spi35_busy_after", busy, 1'b0);

        for (int i = 0; i < 7; i++) begin
            er0 = err_cnt;
            if (vecs[i].is_write)
                do_write($sformatf("v%0d_wr", i), vecs[i].addr, vecs[i].d0, vecs[i].d1,
                         vecs[i].exp_strobes);
            else
                do_read($sformatf("v%0d_rd", i), vecs[i].addr, {vecs[i].d0, vecs[i].d1});
            check($sformatf("v%0d_oe_after", i), bus.sio_oe, 4'h0);
            check($sformatf("v%0d_busy_after", i), busy, 1'b0);
            check($sformatf("v%0d_no_err", i), err_cnt - er0, 0);
        end

        // Abort after one write data nibble: nothing committed
        ws0 = ws_cnt;
        cs_low();
        put_qpi(8'h38);
        put_addr(24'h000010);
        put_nib(4'h7);
        cs_high();
        check("abort_strobes", ws_cnt - ws0, 0);
        do_read("abort_rd", 24'h000010, 16'hA53C);

        // Unsupported QPI command
        er0 = err_cnt;
        cs_low();
        put_qpi(8'h12);
        #(8*TCLK);
        check("cmd12_err", err_cnt - er0, 1);
        check("cmd12_busy", busy, 1'b1);
        cs_high();
        check("cmd12_busy_after", busy, 1'b0);
        check("cmd12_err_once", err_cnt - er0, 1);
        check("cmd12_qpi_kept", qpi_mode, 1'b1);

        // Enter-quad while already in QPI is an error
        er0 = err_cnt;
        cs_low();
        put_qpi(8'h35);
        cs_high();
        check("qpi35_err", err_cnt - er0, 1);
        check("qpi35_qpi_kept", qpi_mode, 1'b1);

        // Exit quad
        er0 = err_cnt;
        cs_low();
        put_qpi(8'hF5);
        cs_high();
        check("f5_qpi_mode", qpi_mode, 1'b0);
        check("f5_no_err", err_cnt - er0, 0);

        // Write command in SPI mode is unsupported
        er0 = err_cnt;
        cs_low();
        put_spi(8'h38);
        cs_high();
        check("spi38_err", err_cnt - er0, 1);
        check("spi38_qpi_mode", qpi_mode, 1'b0);

        // Reset in the middle of a read burst
        cs_low();
        put_spi(8'h35);
        cs_high();
        check("re_enter_qpi", qpi_mode, 1'b1);
        cs_low();
        put_qpi(8'hEB);
        put_addr(24'h000010);
        for (int k = 0; k < 6; k++) get_nib(n, oe);
        get_nib(n, oe);
        check("mid_rd_nib", n, 4'hA);
        check("mid_rd_oe", oe, 4'hF);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_qpi_mode", qpi_mode, 1'b0);
        check("midrst_sio_oe", bus.sio_oe, 4'h0);
        check("midrst_busy", busy, 1'b0);
        bus.chip_enable = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #(10*TCLK);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_oe", bus.sio_oe, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
